mem_port_arbiter: RTL

Two-requester front end for the 16-bit single-port block memory (8192 x 16, synchronous read, write-enable `wea`). Accepts instruction-fetch reads and data loads/stores from the processor, arbitrates between them, drives the memory's `wea`/`addra`/`dina` from registers, and returns `douta` to the winning requester with a one-cycle acknowledge. It sits directly upstream of the memory; the memory's `clka` is the same clock.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port synchronous block memory
//
// Ports:
//   clka, reset                 clock and synchronous active-high reset
//   if_req/if_addr              fetch read request
//   if_ack/if_rdata             fetch acknowledge pulse and returned word
//   d_req/d_we/d_addr/d_wdata   data load/store request
//   d_ack/d_rdata               data acknowledge pulse and loaded word
//   busy                        high whenever a transaction is in flight
//   mem_wea/mem_addra/mem_dina  registered drive to the memory port
//   mem_douta                   memory read data
module mem_port_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_last_d;   // 1 = data port won the last grant
    logic               r_gnt_d;    // 1 = current transaction belongs to the data port
    logic               r_store;
    logic [CNT_W-1:0]   r_lat_cnt;

    logic w_any_req;
    logic w_pick_d;

    assign w_any_req = if_req | d_req;
    // Data wins alone, or on a tie when fetch was the last port served.
    assign w_pick_d  = d_req & (~if_req | ~r_last_d);

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clka) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b0;
            r_gnt_d   <= 1'b0;
            r_store   <= 1'b0;
            r_lat_cnt <= '0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_d   <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_store   <= w_pick_d & d_we;
                        mem_wea   <= w_pick_d & d_we;
                        mem_addra <= w_pick_d ? d_addr : if_addr;
                        // Fetches carry no write data, so dina keeps its last value.
                        if (w_pick_d) begin
                            mem_dina <= d_wdata;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_wea <= 1'b0;
                    if (r_store) begin
                        d_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_lat_cnt <= CNT_W'(MEM_LAT - 1);
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        if (r_gnt_d) begin
                            d_rdata <= mem_douta;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_douta;
                            if_ack   <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
